fb_plot_writer: RTL and testbench
=================================

// Module: fb_plot_writer
// PURPOSE
// Downstream consumer of the drawing engines (fillscreen, circle, etc.).
// - Accepts their per-pixel plot stream (x, y, colour, plot strobe) and buffers it in a small FIFO.
// - Converts each (x,y) into a linear framebuffer address.
// - Issues writes to the shared framebuffer RAM port, which is arbitrated against VGA scanout via a grant.
// - Decouples engine pixel rate from RAM availability; backpressure goes upstream via plot_ready.
// PARAMETERS
// DEPTH     8    FIFO entries (power of 2, >=2)
// SCREEN_W  160  pixels per line
// SCREEN_H  120  lines per frame
// ADDR_W    15   framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
// PORTS
// clk          in   1       system clock, all logic on rising edge
// rst          in   1       reset; asynchronous, active-high
// plot_x       in   8       pixel column from drawing engine
// plot_y       in   7       pixel row from drawing engine
// plot_colour  in   3       pixel colour
// plot_valid   in   1       engine plot strobe; pixel accepted when plot_valid & plot_ready
// plot_ready   out  1       FIFO can accept (= not full), registered
// fb_addr      out  ADDR_W  framebuffer write address = y*SCREEN_W + x
// fb_wdata     out  3       framebuffer write colour
// fb_we        out  1       write request (= FIFO not empty)
// fb_gnt       in   1       arbiter grants the RAM port this cycle; write completes
// drop_cnt     out  16      count of out-of-range pixels discarded, saturating
// idle         out  1       FIFO empty; all accepted pixels written
// BEHAVIOUR
// - Reset (async assert, sync release): FIFO flushed, rd/wr ptrs and count = 0.
//   Outputs under reset: plot_ready=1, fb_we=0, fb_addr=0, fb_wdata=0, drop_cnt=0, idle=1.
//   Reset mid-stream discards all buffered pixels; no partial write is issued after release.
// - Range check at input:
//   - Pixel with plot_x>=SCREEN_W or plot_y>=SCREEN_H is consumed (counts as accepted) but never stored.
//   - Such a pixel increments drop_cnt; drop_cnt sticks at 16'hFFFF.
// - Address computed at push, stored in FIFO as {addr, colour}.
//   - y*160 = (y<<7)+(y<<5); zero-extend to ADDR_W before the add.
//   - Max 119*160+159 = 19199.
// - Accept rule: push when plot_valid & plot_ready & in-range.
//   - plot_ready = (count != DEPTH), derived from the registered count.
// - Write rule:
//   - fb_we = (count != 0).
//   - fb_addr/fb_wdata = head entry, held stable while fb_we=1 and fb_gnt=0.
//   - Pop on fb_we & fb_gnt.
//   - fb_gnt while fb_we=0 is ignored.
// - Latency: pixel accepted at edge N gives fb_we=1 with its data in the cycle after edge N (earliest grant at edge N+1).
// - Throughput: 1 pixel/cycle when fb_gnt held high.
// - Ordering: strict FIFO; writes leave in acceptance order.
// - Simultaneous push+pop: count unchanged, both pointers advance, legal at any non-full count.
// - Full: plot_ready=0, input ignored even if plot_valid=1.
//   - A pop at full raises plot_ready in the next cycle; same-cycle push at full is not permitted.
// - Empty with push: count 0->1; no bypass, so fb_we stays 0 in the push cycle.
// - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
// - idle = (count==0); goes high in the cycle after the final granted pop.
// STRUCTURE
// - fb_pkg (shared): SCREEN_W, SCREEN_H, X_W=8, Y_W=7, COLOUR_W=3, ADDR_W.
//   - typedef struct packed {logic [ADDR_W-1:0] addr; logic [2:0] colour;} fb_px_t.
//   - function xy_to_addr(x,y).
// - Sub-module sync_fifo #(WIDTH, DEPTH): register array, full/empty/count, async active-high reset.
//   - Reused by later VGA stages.
// - Top holds the range check, address arithmetic, drop counter and port mapping.
// TESTING
// 1. Reset then idle: rst=1 for 2 cycles, release -> plot_ready=1, fb_we=0, idle=1, drop_cnt=0.
// 2. Single pixel: x=5, y=3, colour=3'b101, fb_gnt=1.
//    -> fb_we=1 next cycle with fb_addr=485, fb_wdata=5; idle=1 the cycle after.
// 3. Backpressure: fb_gnt=0, stream 9 pixels.
//    -> plot_ready=0 after 8 accepted, 9th held.
//    -> grant once -> ready returns next cycle, 9th accepted.
//    -> grant all -> 9 writes in order.
// 4. Corners/range: (0,0)->0, (159,119)->19199.
//    -> (160,0) and (0,120) dropped: drop_cnt=2, no fb_we for them.
// 5. Full fill: feed 19200-pixel fillscreen stream with fb_gnt random ~50%.
//    -> every address 0..19199 written exactly once, in order, no loss.
// 6. Mid-stream reset: assert rst with 5 entries buffered.
//    -> fb_we=0 immediately (async); after release idle=1, no stale writes.

Source files
------------

// File: rtl/fb_plot_writer_pkg.sv
// Shared framebuffer geometry, pixel entry type and the (x,y) -> linear address helper.
// Also used by the VGA scanout stages.
package fb_plot_writer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;
  localparam int DEPTH    = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        colour;
  } fb_px_t;

  // y*160 built from two shifts; y is widened first so the shifted bits are kept.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] y_w;
    logic [ADDR_W-1:0] x_w;
    y_w = {{(ADDR_W-Y_W){1'b0}}, y};
    x_w = {{(ADDR_W-X_W){1'b0}}, x};
    return (y_w << 4'd7) + (y_w << 4'd5) + x_w;
  endfunction

endpackage

// File: rtl/fb_plot_writer_if.sv
// Plot stream from the drawing engines plus the framebuffer write port.
// slave = the plot writer's view, master = the engine/arbiter side.
interface fb_plot_writer_if;
  import fb_plot_writer_pkg::*;

  logic [X_W-1:0]      plot_x;
  logic [Y_W-1:0]      plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                plot_valid;
  logic                plot_ready;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_wdata;
  logic                fb_we;
  logic                fb_gnt;
  logic [15:0]         drop_cnt;
  logic                idle;

  modport slave (
    input  plot_x, plot_y, plot_colour, plot_valid, fb_gnt,
    output plot_ready, fb_addr, fb_wdata, fb_we, drop_cnt, idle
  );

  modport master (
    output plot_x, plot_y, plot_colour, plot_valid, fb_gnt,
    input  plot_ready, fb_addr, fb_wdata, fb_we, drop_cnt, idle
  );

endinterface

// File: rtl/fb_plot_writer_sync_fifo.sv
// Generic register-array FIFO with full/empty/count; head entry is always visible on rdata.
// Push at full and pop at empty are ignored internally.
module sync_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears contents so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fb_plot_writer.sv
// Buffers the drawing engines' plot stream and writes it to the shared framebuffer port.
// Off-screen pixels are swallowed and counted; the rest are queued as {addr, colour}.
module fb_plot_writer
  import fb_plot_writer_pkg::*;
#(
  parameter int DEPTH    = fb_plot_writer_pkg::DEPTH,
  parameter int SCREEN_W = fb_plot_writer_pkg::SCREEN_W,
  parameter int SCREEN_H = fb_plot_writer_pkg::SCREEN_H,
  parameter int ADDR_W   = fb_plot_writer_pkg::ADDR_W
) (
  input logic              clk,
  input logic              rst,
  fb_plot_writer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  fb_px_t            push_px_s;
  fb_px_t            head_px_s;
  logic [ADDR_W-1:0] px_addr_s;
  logic              in_range_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  count_s;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  assign in_range_s = (bus.plot_x < X_LIM) && (bus.plot_y < Y_LIM);
  assign accept_s   = bus.plot_valid & ~full_s;
  assign push_s     = accept_s & in_range_s;
  assign pop_s      = ~empty_s & bus.fb_gnt;
  assign px_addr_s  = xy_to_addr(bus.plot_x, bus.plot_y);

  // Pack the incoming pixel into a FIFO entry.
  always_comb begin
    push_px_s        = '0;
    push_px_s.addr   = px_addr_s;
    push_px_s.colour = bus.plot_colour;
  end

  sync_fifo #(
    .WIDTH ($bits(fb_px_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_px_s),
    .rdata (head_px_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Saturating count of accepted-but-discarded off-screen pixels.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept_s && !in_range_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.plot_ready = ~full_s;
  assign bus.fb_we      = ~empty_s;
  assign bus.fb_addr    = head_px_s.addr;
  assign bus.fb_wdata   = head_px_s.colour;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.idle       = (count_s == {CNT_W{1'b0}});

endmodule

// File: tb/tb_fb_plot_writer.sv
// Directed self-checking bench for fb_plot_writer.
module tb_fb_plot_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  fb_plot_writer_if bus ();

  fb_plot_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int c, input logic v);
    bus.plot_x      = 8'(x);
    bus.plot_y      = 7'(y);
    bus.plot_colour = 3'(c);
    bus.plot_valid  = v;
  endtask

  function automatic int px_x(input int i); return 10 + i; endfunction
  function automatic int px_y(input int i); return i * 13; endfunction

  initial begin
    int exp_wr;
    int cur;
    int cyc;
    logic acc;
    logic wr;

    drive(0, 0, 0, 1'b0);
    bus.fb_gnt = 1'b0;

    // 1. reset then idle
    rst = 1'b1;
    tick();
    tick();
    check("rst_we", 32'(bus.fb_we), 32'd0);
    check("rst_ready", 32'(bus.plot_ready), 32'd1);
    check("rst_addr", 32'(bus.fb_addr), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(bus.plot_ready), 32'd1);
    check("idle_we", 32'(bus.fb_we), 32'd0);
    check("idle_idle", 32'(bus.idle), 32'd1);
    check("idle_drop", 32'(bus.drop_cnt), 32'd0);

    // 2. single pixel
    bus.fb_gnt = 1'b1;
    drive(5, 3, 5, 1'b1);
    check("single_no_bypass", 32'(bus.fb_we), 32'd0);
    tick();
    drive(0, 0, 0, 1'b0);
    check("single_we", 32'(bus.fb_we), 32'd1);
    check("single_addr", 32'(bus.fb_addr), 32'd485);
    check("single_data", 32'(bus.fb_wdata), 32'd5);
    tick();
    check("single_idle", 32'(bus.idle), 32'd1);
    check("single_we_off", 32'(bus.fb_we), 32'd0);

    // 3. backpressure
    bus.fb_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(px_x(i), px_y(i), i % 8, 1'b1);
      tick();
    end
    check("bp_full_ready", 32'(bus.plot_ready), 32'd0);
    check("bp_head_addr", 32'(bus.fb_addr), 32'(px_y(0) * 160 + px_x(0)));
    drive(px_x(8), px_y(8), 8 % 8, 1'b1);
    tick();
    check("bp_9th_held", 32'(bus.plot_ready), 32'd0);
    check("bp_head_stable", 32'(bus.fb_addr), 32'(px_y(0) * 160 + px_x(0)));
    bus.fb_gnt = 1'b1;
    tick();
    check("bp_ready_back", 32'(bus.plot_ready), 32'd1);
    check("bp_head1", 32'(bus.fb_addr), 32'(px_y(1) * 160 + px_x(1)));
    bus.fb_gnt = 1'b0;
    tick();
    drive(0, 0, 0, 1'b0);
    check("bp_9th_taken", 32'(bus.plot_ready), 32'd0);
    bus.fb_gnt = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("bp_wr_addr%0d", k), 32'(bus.fb_addr), 32'(px_y(k) * 160 + px_x(k)));
      check($sformatf("bp_wr_data%0d", k), 32'(bus.fb_wdata), 32'(k % 8));
      tick();
    end
    check("bp_drained", 32'(bus.idle), 32'd1);

    // 4. corners and range
    drive(0, 0, 1, 1'b1);
    tick();
    check("corner0_we", 32'(bus.fb_we), 32'd1);
    check("corner0_addr", 32'(bus.fb_addr), 32'd0);
    drive(159, 119, 7, 1'b1);
    tick();
    check("corner1_addr", 32'(bus.fb_addr), 32'd19199);
    check("corner1_data", 32'(bus.fb_wdata), 32'd7);
    drive(160, 0, 2, 1'b1);
    tick();
    check("drop_x_we", 32'(bus.fb_we), 32'd0);
    check("drop_x_cnt", 32'(bus.drop_cnt), 32'd1);
    drive(0, 120, 2, 1'b1);
    tick();
    check("drop_y_we", 32'(bus.fb_we), 32'd0);
    check("drop_y_cnt", 32'(bus.drop_cnt), 32'd2);
    drive(0, 0, 0, 1'b0);
    tick();
    check("drop_hold", 32'(bus.drop_cnt), 32'd2);
    check("drop_idle", 32'(bus.idle), 32'd1);

    // 5. full-screen fill with ~50% grant
    exp_wr = 0;
    cur    = 0;
    cyc    = 0;
    drive(0, 0, 0, 1'b1);
    while (exp_wr < 19200 && cyc < 80000) begin
      bus.fb_gnt = 1'($urandom_range(0, 1));
      acc = bus.plot_valid & bus.plot_ready;
      wr  = bus.fb_we & bus.fb_gnt;
      if (wr) begin
        check("fill_addr", 32'(bus.fb_addr), 32'(exp_wr));
        check("fill_data", 32'(bus.fb_wdata), 32'(exp_wr % 8));
        exp_wr++;
      end
      tick();
      cyc++;
      if (acc) begin
        cur++;
        if (cur < 19200) drive(cur % 160, cur / 160, cur % 8, 1'b1);
        else             drive(0, 0, 0, 1'b0);
      end
    end
    check("fill_count", 32'(exp_wr), 32'd19200);
    check("fill_idle", 32'(bus.idle), 32'd1);
    check("fill_no_drop", 32'(bus.drop_cnt), 32'd2);

    // 6. mid-stream reset
    bus.fb_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(px_x(i), px_y(i), i, 1'b1);
      tick();
    end
    drive(0, 0, 0, 1'b0);
    check("mid_we_before", 32'(bus.fb_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_we_async", 32'(bus.fb_we), 32'd0);
    check("mid_idle_async", 32'(bus.idle), 32'd1);
    check("mid_addr_async", 32'(bus.fb_addr), 32'd0);
    check("mid_drop_async", 32'(bus.drop_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.fb_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_no_stale%0d", i), 32'(bus.fb_we), 32'd0);
    end
    check("mid_idle_after", 32'(bus.idle), 32'd1);
    check("mid_ready_after", 32'(bus.plot_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
